// File: rtl/tick_countdown_timer.sv
// rtl/tick_countdown_timer.sv - slow_clock edge-to-tick converter driving a loadable countdown timer
// States: IDLE, RUN, PAUSE, DONE. Per-cycle priority: clear > start > pause > tick.
module tick_countdown_timer #(
  parameter int COUNT_WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_FPGA,
  input  logic                   reset,
  input  logic                   slow_clock_i,
  input  logic [COUNT_WIDTH-1:0] load_value_i,
  input  logic                   start_i,
  input  logic                   pause_i,
  input  logic                   clear_i,
  output logic                   tick_o,
  output logic [COUNT_WIDTH-1:0] count_value_o,
  output logic                   running_o,
  output logic                   done_pulse_o,
  output logic                   expired_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [1:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   done_q, done_d;
  logic                   running_q, expired_q;

  // slow_clock is asynchronous; only the last chain stage is trusted
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clock_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_o = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start_i) begin
      if (state_q == ST_PAUSE) begin
        state_d = ST_RUN;
      end else begin
        count_d = load_value_i;
        if (load_value_i == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
    end else if (pause_i && (state_q == ST_RUN)) begin
      state_d = ST_PAUSE;
    end else if (tick_o && (state_q == ST_RUN)) begin
      // Leaving RUN at 1 -> 0 is what keeps the decrement from ever wrapping
      if (count_q == COUNT_WIDTH'(1)) begin
        count_d = '0;
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        count_d = count_q - COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_DONE);
    end
  end

  assign count_value_o = count_q;
  assign running_o     = running_q;
  assign done_pulse_o  = done_q;
  assign expired_o     = expired_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// tb/tb_tick_countdown_timer.sv - randomized and directed bench for tick_countdown_timer against a behavioural model
module tb_tick_countdown_timer;

  localparam int W = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic         clk_FPGA = 1'b0;
  logic         reset = 1'b0;
  logic         slow_clock = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic         tick;
  logic [W-1:0] count_value;
  logic         running, done_pulse, expired;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;
  int done_cnt = 0;

  tick_countdown_timer #(.COUNT_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_FPGA     (clk_FPGA),
    .reset        (reset),
    .slow_clock_i (slow_clock),
    .load_value_i (load_value),
    .start_i      (start),
    .pause_i      (pause),
    .clear_i      (clear),
    .tick_o       (tick),
    .count_value_o(count_value),
    .running_o    (running),
    .done_pulse_o (done_pulse),
    .expired_o    (expired)
  );

  always #5 clk_FPGA = ~clk_FPGA;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: samp[k] is slow_clock as sampled k edges ago; a tick is a 0->1 seen two samples late
  int           m_mode;
  logic [W-1:0] m_count;
  logic         m_done;
  logic [2:0]   samp;
  logic         m_tick;
  assign m_tick = samp[1] & ~samp[2];

  always @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      samp    <= '0;
      m_mode  <= M_IDLE;
      m_count <= '0;
      m_done  <= 1'b0;
    end else begin
      samp   <= {samp[1:0], slow_clock};
      m_done <= 1'b0;
      if (clear) begin
        m_mode  <= M_IDLE;
        m_count <= '0;
      end else if (start && m_mode == M_PAUSE) begin
        m_mode <= M_RUN;
      end else if (start) begin
        m_count <= load_value;
        m_mode  <= (load_value == 0) ? M_DONE : M_RUN;
        m_done  <= (load_value == 0);
      end else if (pause && m_mode == M_RUN) begin
        m_mode <= M_PAUSE;
      end else if (m_tick && m_mode == M_RUN) begin
        m_count <= m_count - 1;
        if (m_count == 1) begin
          m_mode <= M_DONE;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk_FPGA) begin
    check("tick", tick, m_tick);
    check("count_value", count_value, m_count);
    check("running", running, m_mode == M_RUN);
    check("done_pulse", done_pulse, m_done);
    check("expired", expired, m_mode == M_DONE);
    if (tick) tick_cnt <= tick_cnt + 1;
    if (done_pulse) done_cnt <= done_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk_FPGA);
      #1;
    end
  endtask

  task automatic ticks(input int k);
    repeat (k) begin
      slow_clock = 1'b1;
      cyc(4);
      slow_clock = 1'b0;
      cyc(4);
    end
  endtask

  task automatic pulse_start(input int v);
    load_value = W'(v);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    int t0, d0;
    cyc(2);
    check("reset_count", count_value, 0);
    check("reset_running", running, 0);
    check("reset_expired", expired, 0);
    check("reset_done", done_pulse, 0);
    check("reset_tick", tick, 0);
    reset = 1'b1;
    cyc(3);

    // tick generation and latency
    t0 = tick_cnt;
    ticks(10);
    cyc(2);
    check("tick_gen_count", tick_cnt - t0, 10);
    slow_clock = 1'b1;
    cyc(1);
    check("tick_lat_e0", tick, 0);
    cyc(1);
    check("tick_lat_e1", tick, 1);
    cyc(1);
    check("tick_lat_e2", tick, 0);
    slow_clock = 1'b0;
    cyc(4);

    // basic countdown
    d0 = done_cnt;
    pulse_start(3);
    check("basic_load", count_value, 3);
    check("basic_running", running, 1);
    ticks(3);
    check("basic_end_count", count_value, 0);
    check("basic_expired", expired, 1);
    check("basic_not_running", running, 0);
    check("basic_done_once", done_cnt - d0, 1);

    // pause / resume without reload
    pulse_start(5);
    ticks(2);
    check("pause_pre", count_value, 3);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    ticks(4);
    check("pause_hold", count_value, 3);
    check("pause_not_running", running, 0);
    pulse_start(9);
    check("resume_no_reload", count_value, 3);
    check("resume_running", running, 1);
    ticks(3);
    check("resume_end", count_value, 0);
    check("resume_expired", expired, 1);

    // clear beats start
    pulse_start(7);
    ticks(1);
    clear = 1'b1;
    start = 1'b1;
    cyc(1);
    clear = 1'b0;
    start = 1'b0;
    check("clear_start_count", count_value, 0);
    check("clear_start_running", running, 0);
    check("clear_start_expired", expired, 0);

    // pause coincident with a tick
    pulse_start(2);
    slow_clock = 1'b1;
    cyc(2);
    check("coincide_tick", tick, 1);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("coincide_count", count_value, 2);
    check("coincide_paused", running, 0);
    slow_clock = 1'b0;
    cyc(3);

    // zero load goes straight to DONE
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    d0 = done_cnt;
    pulse_start(0);
    check("zero_expired", expired, 1);
    check("zero_count", count_value, 0);
    cyc(3);
    check("zero_done_once", done_cnt - d0, 1);

    // restart from DONE with maximum load
    d0 = done_cnt;
    pulse_start(255);
    check("max_load", count_value, 255);
    check("max_running", running, 1);
    ticks(255);
    check("max_end", count_value, 0);
    check("max_done_once", done_cnt - d0, 1);
    ticks(2);
    check("max_no_wrap", count_value, 0);
    check("max_expired", expired, 1);

    // asynchronous reset mid-run
    pulse_start(6);
    ticks(2);
    check("mid_pre_reset", count_value, 4);
    #6;
    reset = 1'b0;
    #1;
    check("async_count", count_value, 0);
    check("async_running", running, 0);
    check("async_expired", expired, 0);
    check("async_done", done_pulse, 0);
    check("async_tick", tick, 0);
    slow_clock = 1'b1;
    cyc(2);
    reset = 1'b1;
    t0 = tick_cnt;
    cyc(6);
    check("post_reset_ticks", tick_cnt - t0, 1);
    check("post_reset_count", count_value, 0);
    check("post_reset_idle", running, 0);
    slow_clock = 1'b0;
    cyc(2);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      start      = ($urandom % 14) == 0;
      pause      = ($urandom % 12) == 0;
      clear      = ($urandom % 50) == 0;
      load_value = W'($urandom % 9);
      if (($urandom % 3) == 0) slow_clock = ~slow_clock;
      cyc(1);
    end
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_countdown_timer.md
Name: tick_countdown_timer

Overview:
- Consumes the slow `clock_signal` produced by the clock-divider stage and converts its rising edges into single-cycle ticks in the `clk_FPGA` domain.
- Uses those ticks to run a loadable countdown timer with start, pause, resume and clear control.
- Reports the current count, a running flag, a one-cycle done pulse and a sticky expired flag.
- Sits directly downstream of the divider; typical consumers are display drivers and control FSMs that need a seconds/milliseconds timebase.

Parameters:
- COUNT_WIDTH, 8, width of the load value and of the countdown register.
- SYNC_STAGES, 2, number of flip-flops synchronising `slow_clock` into `clk_FPGA`; minimum 2.

Ports:
- clk_FPGA  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- slow_clock  input  1  divided clock from the divider stage; treated as asynchronous data.
- load_value  input  COUNT_WIDTH  start value, sampled on an accepted start.
- start  input  1  level sampled each cycle; load-and-run from IDLE, RUN or DONE; resume (no reload) from PAUSE.
- pause  input  1  RUN -> PAUSE.
- clear  input  1  any state -> IDLE; count forced to 0.
- tick  output  1  one-cycle pulse per synchronised rising edge of `slow_clock`.
- count_value  output  COUNT_WIDTH  current countdown value.
- running  output  1  high only in RUN.
- done_pulse  output  1  one-cycle pulse on entry to DONE.
- expired  output  1  high while in DONE.

Behaviour:
- Reset and interface: reset is asynchronous, active-low; clock is `clk_FPGA`.
- Reset values: all sync flops 0, edge-history flop 0, state IDLE, `count_value` 0, `running` 0, `done_pulse` 0, `expired` 0, `tick` 0.

Synchroniser and edge detect:
- The synchroniser is a chain of SYNC_STAGES flops; the last stage is `sync_q`.
- `prev_q` registers `sync_q`.
- `tick` = `sync_q` AND NOT `prev_q`. It is driven only by flop outputs, so it is glitch-free.
- Latency with SYNC_STAGES=2: `slow_clock` is sampled high at edge E0, `tick` is high between E1 and E2, and the count update lands at E2.
- Exactly one tick per `slow_clock` rising edge; falling edges produce nothing.
- `slow_clock` high at reset release yields one tick; this is harmless because ticks act only in RUN.

FSM states: IDLE, RUN, PAUSE, DONE. Per-cycle priority: clear > start > pause > tick.
- Any state, clear=1: go to IDLE, count=0, `done_pulse`=0.
- IDLE, start=1: load `count_value`=`load_value`. If `load_value`==0, go directly to DONE with `done_pulse`. Otherwise go to RUN.
- RUN, start=1: restart; reload `load_value` with the same zero rule.
- RUN, pause=1: go to PAUSE; a coincident tick is discarded.
- RUN, tick=1:
  - If count==1: count becomes 0, go to DONE, `done_pulse`=1 for exactly the next cycle.
  - Else: count decrements by 1.
- PAUSE, start=1: go to RUN with no reload and count unchanged. Ticks are ignored in PAUSE.
- DONE: `expired`=1, count holds 0. start=1 reloads as in IDLE. Ticks are ignored.
- IDLE: count holds its value; ticks are ignored.

Arithmetic and other rules:
- Decrement is unsigned COUNT_WIDTH. Underflow is impossible because the FSM leaves RUN at 1 -> 0.
- Maximum load is 2^COUNT_WIDTH-1 with no wrap.
- `running`, `expired` and `done_pulse` are registered and aligned with the state register.
- Mid-operation reset returns everything to its reset value immediately (asynchronous).
- `tick` is always emitted regardless of FSM state.

Test Plan:
- Tick generation: `slow_clock` toggles every 4 `clk_FPGA` cycles, 10 rising edges -> exactly 10 one-cycle `tick` pulses, each 2 cycles after the sampled rise (SYNC_STAGES=2), none on falling edges.
- Basic countdown: `load_value`=3, start for 1 cycle, then 3 ticks -> `count_value` 3,2,1,0; `done_pulse` high exactly 1 cycle when count reaches 0; `expired`=1 and `running`=0 afterwards.
- Pause/resume: `load_value`=5, run 2 ticks (count=3), assert pause, apply 4 ticks -> count stays 3. Assert start -> resumes at 3 and reaches 0 after 3 more ticks.
- Priorities: clear and start together in RUN -> IDLE with count=0. Pause and tick in the same cycle with count=2 -> PAUSE, count stays 2. `load_value`=0 with start -> DONE immediately with a single `done_pulse`.
- Restart: in DONE, start with `load_value`=255 -> count=255, RUN; 255 ticks -> count 0, `done_pulse` once, no wrap to 255.
- Reset mid-operation: `reset` pulled low while count=4 in RUN -> all outputs 0 asynchronously. After release with `slow_clock` held high -> one `tick`, and `count_value` stays 0 in IDLE.
